// File: rtl/sync_frame_extract.sv
// sync_frame_extract: gates a fixed-length frame out of the correlator's delayed
// sample stream after each accepted peak strobe. It also de-rotates every sample
// by the conjugate of the latched peak.
// Optional build macro: SYNC_FRAME_EXTRACT_DROP_CNT_EN adds the drop_cnt output,
// which counts peak strobes ignored while a frame is pending or in progress.
module sync_frame_extract #(
  parameter int DW    = 12,
  parameter int PW    = 18,
  parameter int CW    = 14,
  parameter int SHIFT = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] idata_i,
  input  logic signed [DW-1:0] idata_q,
  input  logic                 isop,
  input  logic signed [PW-1:0] ipeak_i,
  input  logic signed [PW-1:0] ipeak_q,
  input  logic        [CW-1:0] start_ofs,
  input  logic        [CW-1:0] frame_len,
  output logic signed [DW-1:0] odata_i,
  output logic signed [DW-1:0] odata_q,
  output logic                 oval,
  output logic                 osop,
  output logic                 oeop,
  output logic                 busy
`ifdef SYNC_FRAME_EXTRACT_DROP_CNT_EN
  ,
  output logic        [15:0]   drop_cnt
`endif
);

  localparam int PRW = DW + PW;  // full product width

  // Saturation bounds expressed at the widened sum width.
  localparam logic signed [PRW:0] SAT_MAX = (PRW+1)'((1 << (DW-1)) - 1);
  localparam logic signed [PRW:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FRAME = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         ofs_cnt_q, ofs_cnt_d;
  logic [CW-1:0]         len_cnt_q, len_cnt_d;
  logic [CW-1:0]         len_q;
  logic signed [PW-1:0]  pk_i_q, pk_q_q;
  logic                  accept;   // isop taken in IDLE with a non-zero length
  logic                  take;     // current input sample belongs to the frame
  logic                  first;
  logic                  last;

  // Next-state logic: frame start offset and length counting.
  always_comb begin
    state_d   = state_q;
    ofs_cnt_d = ofs_cnt_q;
    len_cnt_d = len_cnt_q;
    accept    = 1'b0;
    take      = 1'b0;
    first     = 1'b0;
    last      = 1'b0;
    case (state_q)
      IDLE: begin
        if (isop && (frame_len != '0)) begin
          accept    = 1'b1;
          len_cnt_d = '0;
          if (start_ofs == '0) begin
            state_d = FRAME;
          end else begin
            state_d   = WAIT;
            ofs_cnt_d = start_ofs;
          end
        end
      end
      WAIT: begin
        ofs_cnt_d = ofs_cnt_q - CW'(1);
        if (ofs_cnt_q == CW'(1)) begin
          state_d   = FRAME;
          len_cnt_d = '0;
        end
      end
      FRAME: begin
        take  = 1'b1;
        first = (len_cnt_q == '0);
        last  = (len_cnt_q == len_q - CW'(1));
        if (last) begin
          state_d   = IDLE;
          len_cnt_d = '0;
        end else begin
          len_cnt_d = len_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and the peak/length latched on an accepted strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ofs_cnt_q <= '0;
      len_cnt_q <= '0;
      len_q     <= '0;
      pk_i_q    <= '0;
      pk_q_q    <= '0;
    end else begin
      state_q   <= state_d;
      ofs_cnt_q <= ofs_cnt_d;
      len_cnt_q <= len_cnt_d;
      if (accept) begin
        len_q  <= frame_len;
        pk_i_q <= ipeak_i;
        pk_q_q <= ipeak_q;
      end
    end
  end

  assign busy = (state_q == WAIT) || (state_q == FRAME);

  // Stage 1 registers: the four partial products plus frame markers.
  logic signed [PRW-1:0] p0_q, p1_q, p2_q, p3_q;
  logic                  v1_q, sop1_q, eop1_q;

  // Stage 1: multiply the frame sample by the latched peak.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_q   <= '0;
      p1_q   <= '0;
      p2_q   <= '0;
      p3_q   <= '0;
      v1_q   <= 1'b0;
      sop1_q <= 1'b0;
      eop1_q <= 1'b0;
    end else begin
      v1_q   <= take;
      sop1_q <= take & first;
      eop1_q <= take & last;
      if (take) begin
        p0_q <= PRW'(idata_i) * PRW'(pk_i_q);
        p1_q <= PRW'(idata_q) * PRW'(pk_q_q);
        p2_q <= PRW'(idata_q) * PRW'(pk_i_q);
        p3_q <= PRW'(idata_i) * PRW'(pk_q_q);
      end
    end
  end

  // Conjugate multiply: (d_i + j d_q) * (pk_i - j pk_q).
  logic signed [PRW:0] s_i, s_q, sh_i, sh_q;
  assign s_i  = (PRW+1)'(p0_q) + (PRW+1)'(p1_q);
  assign s_q  = (PRW+1)'(p2_q) - (PRW+1)'(p3_q);
  assign sh_i = s_i >>> SHIFT;
  assign sh_q = s_q >>> SHIFT;

  function automatic logic signed [DW-1:0] sat(input logic signed [PRW:0] v);
    logic signed [PRW:0] c;
    if (v > SAT_MAX)      c = SAT_MAX;
    else if (v < SAT_MIN) c = SAT_MIN;
    else                  c = v;
    return c[DW-1:0];
  endfunction

  // Stage 2: saturate to sample width; data holds between frame samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      odata_i <= '0;
      odata_q <= '0;
      oval    <= 1'b0;
      osop    <= 1'b0;
      oeop    <= 1'b0;
    end else begin
      oval <= v1_q;
      osop <= sop1_q;
      oeop <= eop1_q;
      if (v1_q) begin
        odata_i <= sat(sh_i);
        odata_q <= sat(sh_q);
      end
    end
  end

`ifdef SYNC_FRAME_EXTRACT_DROP_CNT_EN
  logic [15:0] drop_q;

  // Count strobes ignored because a frame is already pending or running.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (isop && (state_q != IDLE) && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_sync_frame_extract.sv
// Testbench for sync_frame_extract: directed scenarios use hand-derived
// constants, and a randomized run is checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_sync_frame_extract;
  localparam int DW = 12;
  localparam int PW = 18;
  localparam int CW = 14;
  localparam int NC = 400;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] idata_i, idata_q, odata_i, odata_q;
  logic                 isop;
  logic signed [PW-1:0] ipeak_i, ipeak_q;
  logic        [CW-1:0] start_ofs, frame_len;
  logic                 oval, osop, oeop, busy;
`ifdef SYNC_FRAME_EXTRACT_DROP_CNT_EN
  logic        [15:0]   drop_cnt;
`endif

  always #5 clk = ~clk;

  sync_frame_extract dut (
    .clk(clk), .rst(rst),
    .idata_i(idata_i), .idata_q(idata_q),
    .isop(isop), .ipeak_i(ipeak_i), .ipeak_q(ipeak_q),
    .start_ofs(start_ofs), .frame_len(frame_len),
    .odata_i(odata_i), .odata_q(odata_q),
    .oval(oval), .osop(osop), .oeop(oeop), .busy(busy)
`ifdef SYNC_FRAME_EXTRACT_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle stimulus and recorded outputs; index = cycle within a run.
  int s_rst[NC], s_isop[NC], s_pi[NC], s_pq[NC], s_ofs[NC], s_len[NC], s_di[NC], s_dq[NC];
  int r_oi[NC], r_oq[NC], r_val[NC], r_sop[NC], r_eop[NC], r_busy[NC], r_drop[NC];

  task automatic clear_stim();
    for (int c = 0; c < NC; c++) begin
      s_rst[c] = 0; s_isop[c] = 0; s_ofs[c] = 0; s_len[c] = 0;
      s_pi[c] = int'($urandom_range(0, 262143)) - 131072;  // only meaningful with isop
      s_pq[c] = int'($urandom_range(0, 262143)) - 131072;
      s_di[c] = int'($urandom_range(0, 4095)) - 2048;
      s_dq[c] = int'($urandom_range(0, 4095)) - 2048;
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are recorded at the falling edge.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      rst       = (s_rst[c] != 0);
      isop      = (s_isop[c] != 0);
      ipeak_i   = PW'(s_pi[c]);
      ipeak_q   = PW'(s_pq[c]);
      start_ofs = CW'(s_ofs[c]);
      frame_len = CW'(s_len[c]);
      idata_i   = DW'(s_di[c]);
      idata_q   = DW'(s_dq[c]);
      @(negedge clk);
      r_oi[c]   = int'(odata_i);
      r_oq[c]   = int'(odata_q);
      r_val[c]  = int'(oval);
      r_sop[c]  = int'(osop);
      r_eop[c]  = int'(oeop);
      r_busy[c] = int'(busy);
`ifdef SYNC_FRAME_EXTRACT_DROP_CNT_EN
      r_drop[c] = int'(drop_cnt);
`else
      r_drop[c] = 0;
`endif
    end
  endtask

  task automatic fill_data(input int di, input int dq);
    for (int c = 0; c < NC; c++) begin s_di[c] = di; s_dq[c] = dq; end
  endtask

  function automatic int sat_ref(input longint v);
    longint s = v >>> 10;
    if (s > 2047)  return 2047;
    if (s < -2048) return -2048;
    return int'(s);
  endfunction

  task automatic test_reset();
    clear_stim();
    for (int c = 0; c < 4; c++) s_rst[c] = 1;
    s_isop[2] = 1; s_len[2] = 4;
    run(10);
    for (int c = 1; c < 10; c++) begin
      n_checks++;
      if (r_val[c] !== 0 || r_sop[c] !== 0 || r_eop[c] !== 0 || r_busy[c] !== 0) begin
        n_fail++; $display("FAIL reset_strobes cyc %0d: got val/sop/eop/busy %0d%0d%0d%0d expected 0000", c, r_val[c], r_sop[c], r_eop[c], r_busy[c]);
      end
      n_checks++;
      if (r_oi[c] !== 0 || r_oq[c] !== 0 || r_drop[c] !== 0) begin
        n_fail++; $display("FAIL reset_data cyc %0d: got (%0d,%0d) drop %0d expected (0,0) drop 0", c, r_oi[c], r_oq[c], r_drop[c]);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_rotation(input string nm, input int pki, input int pkq, input int ei, input int eq);
    clear_stim(); fill_data(100, -50);
    s_rst[0] = 1; s_isop[3] = 1; s_pi[3] = pki; s_pq[3] = pkq; s_len[3] = 4;
    run(14);
    for (int c = 4; c < 14; c++) begin
      int ev = (c >= 6 && c <= 9) ? 1 : 0;
      n_checks++;
      if (r_val[c] !== ev) begin n_fail++; $display("FAIL %s_val cyc %0d: got %0d expected %0d", nm, c, r_val[c], ev); end
      n_checks++;
      if (r_busy[c] !== ((c >= 4 && c <= 7) ? 1 : 0)) begin n_fail++; $display("FAIL %s_busy cyc %0d: got %0d", nm, c, r_busy[c]); end
      if (ev == 1) begin
        n_checks++;
        if (r_oi[c] !== ei || r_oq[c] !== eq) begin n_fail++; $display("FAIL %s_data cyc %0d: got (%0d,%0d) expected (%0d,%0d)", nm, c, r_oi[c], r_oq[c], ei, eq); end
        n_checks++;
        if (r_sop[c] !== int'(c == 6) || r_eop[c] !== int'(c == 9)) begin n_fail++; $display("FAIL %s_sopeop cyc %0d: got sop %0d eop %0d", nm, c, r_sop[c], r_eop[c]); end
      end
    end
    $display("test_%s done", nm);
  endtask

  task automatic test_offset_timing();
    clear_stim();
    for (int c = 0; c < NC; c++) begin s_di[c] = c; s_dq[c] = 0; end
    s_rst[0] = 1; s_isop[10] = 1; s_pi[10] = 1024; s_pq[10] = 0; s_ofs[10] = 5; s_len[10] = 3;
    run(24);
    for (int c = 11; c < 24; c++) begin
      int ev = (c >= 18 && c <= 20) ? 1 : 0;
      int eb = (c >= 11 && c <= 18) ? 1 : 0;
      n_checks++;
      if (r_val[c] !== ev) begin n_fail++; $display("FAIL offset_val cyc %0d: got %0d expected %0d", c, r_val[c], ev); end
      n_checks++;
      if (r_busy[c] !== eb) begin n_fail++; $display("FAIL offset_busy cyc %0d: got %0d expected %0d", c, r_busy[c], eb); end
      if (ev == 1) begin
        n_checks++;
        if (r_oi[c] !== c - 2) begin n_fail++; $display("FAIL offset_data cyc %0d: got %0d expected %0d", c, r_oi[c], c - 2); end
      end
    end
    $display("test_offset_timing done");
  endtask

  task automatic test_saturation();
    clear_stim();
    s_rst[0] = 1; s_isop[3] = 1; s_pi[3] = 131071; s_pq[3] = 0; s_len[3] = 2;
    s_di[4] = 2047;  s_dq[4] = 2047;
    s_di[5] = -2048; s_dq[5] = 0;
    run(10);
    n_checks++;
    if (r_val[6] !== 1 || r_oi[6] !== 2047 || r_oq[6] !== 2047) begin n_fail++; $display("FAIL sat_pos: got val %0d (%0d,%0d) expected 1 (2047,2047)", r_val[6], r_oi[6], r_oq[6]); end
    n_checks++;
    if (r_val[7] !== 1 || r_oi[7] !== -2048 || r_oq[7] !== 0) begin n_fail++; $display("FAIL sat_neg: got val %0d (%0d,%0d) expected 1 (-2048,0)", r_val[7], r_oi[7], r_oq[7]); end
    $display("test_saturation done");
  endtask

  task automatic test_edge_lengths();
    clear_stim();
    s_rst[0] = 1; s_isop[3] = 1; s_pi[3] = 1024; s_pq[3] = 0; s_len[3] = 1;
    s_isop[12] = 1; s_len[12] = 0; s_ofs[12] = 2;
    run(22);
    for (int c = 4; c < 11; c++) begin
      n_checks++;
      if (r_val[c] !== int'(c == 6)) begin n_fail++; $display("FAIL len1_val cyc %0d: got %0d expected %0d", c, r_val[c], int'(c == 6)); end
    end
    n_checks++;
    if (r_sop[6] !== 1 || r_eop[6] !== 1) begin n_fail++; $display("FAIL len1_sopeop: got sop %0d eop %0d expected 1 1", r_sop[6], r_eop[6]); end
    for (int c = 13; c < 22; c++) begin
      n_checks++;
      if (r_val[c] !== 0 || r_busy[c] !== 0) begin n_fail++; $display("FAIL len0 cyc %0d: got val %0d busy %0d expected 0 0", c, r_val[c], r_busy[c]); end
      n_checks++;
      if (r_drop[c] !== 0) begin n_fail++; $display("FAIL len0_drop cyc %0d: got %0d expected 0", c, r_drop[c]); end
    end
    $display("test_edge_lengths done");
  endtask

  task automatic test_overlap();
    int cnt = 0;
    clear_stim(); fill_data(100, -50);
    s_rst[0] = 1;
    s_isop[3] = 1; s_pi[3] = 1024; s_pq[3] = 0; s_len[3] = 8;
    s_isop[5] = 1; s_pi[5] = 0; s_pq[5] = 1024; s_len[5] = 8; s_ofs[5] = 2;
    run(26);
    for (int c = 1; c < 26; c++) cnt += r_val[c];
    n_checks++;
    if (cnt !== 8) begin n_fail++; $display("FAIL overlap_count: got %0d oval cycles expected 8", cnt); end
    n_checks++;
    if (r_eop[13] !== 1 || r_oi[13] !== 100 || r_val[14] !== 0) begin n_fail++; $display("FAIL overlap_end: got eop %0d data %0d next val %0d expected 1 100 0", r_eop[13], r_oi[13], r_val[14]); end
`ifdef SYNC_FRAME_EXTRACT_DROP_CNT_EN
    n_checks++;
    if (r_drop[25] !== 1) begin n_fail++; $display("FAIL overlap_drop: got %0d expected 1", r_drop[25]); end
`endif
    $display("test_overlap done");
  endtask

  task automatic test_back_to_back();
    clear_stim(); fill_data(100, -50);
    s_rst[0] = 1;
    s_isop[3] = 1; s_pi[3] = 1024; s_pq[3] = 0; s_len[3] = 4;
    s_isop[7] = 1; s_pi[7] = 1024; s_pq[7] = 0; s_len[7] = 5;
    s_isop[8] = 1; s_pi[8] = 0; s_pq[8] = 1024; s_len[8] = 3;
    run(20);
    for (int c = 4; c < 20; c++) begin
      int ev = ((c >= 6 && c <= 9) || (c >= 11 && c <= 13)) ? 1 : 0;
      int eb = ((c >= 4 && c <= 7) || (c >= 9 && c <= 11)) ? 1 : 0;
      n_checks++;
      if (r_val[c] !== ev) begin n_fail++; $display("FAIL b2b_val cyc %0d: got %0d expected %0d", c, r_val[c], ev); end
      n_checks++;
      if (r_busy[c] !== eb) begin n_fail++; $display("FAIL b2b_busy cyc %0d: got %0d expected %0d", c, r_busy[c], eb); end
    end
    n_checks++;
    if (r_sop[11] !== 1 || r_eop[13] !== 1 || r_oi[12] !== -50 || r_oq[12] !== -100) begin
      n_fail++; $display("FAIL b2b_second: got sop %0d eop %0d data (%0d,%0d) expected 1 1 (-50,-100)", r_sop[11], r_eop[13], r_oi[12], r_oq[12]);
    end
`ifdef SYNC_FRAME_EXTRACT_DROP_CNT_EN
    n_checks++;
    if (r_drop[19] !== 1) begin n_fail++; $display("FAIL b2b_drop: got %0d expected 1", r_drop[19]); end
`endif
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_midframe();
    int eops = 0;
    clear_stim(); fill_data(100, -50);
    s_rst[0] = 1; s_isop[3] = 1; s_pi[3] = 1024; s_pq[3] = 0; s_len[3] = 10;
    s_rst[8] = 1;
    run(22);
    for (int c = 6; c <= 8; c++) begin
      n_checks++;
      if (r_val[c] !== 1 || r_oi[c] !== 100) begin n_fail++; $display("FAIL midrst_pre cyc %0d: got val %0d data %0d expected 1 100", c, r_val[c], r_oi[c]); end
    end
    for (int c = 9; c < 22; c++) begin
      n_checks++;
      if (r_val[c] !== 0 || r_busy[c] !== 0 || r_oi[c] !== 0) begin n_fail++; $display("FAIL midrst_post cyc %0d: got val %0d busy %0d data %0d expected 0 0 0", c, r_val[c], r_busy[c], r_oi[c]); end
    end
    for (int c = 1; c < 22; c++) eops += r_eop[c];
    n_checks++;
    if (eops !== 0) begin n_fail++; $display("FAIL midrst_eop: got %0d eop pulses expected 0", eops); end
    $display("test_reset_midframe done");
  endtask

  // Reference model works per frame: each accepted strobe schedules its busy
  // window and its output samples; a reset cancels everything scheduled after it.
  task automatic test_random(input int iter);
    int n = 320;
    int busy_end, rcyc, cur_i, cur_q, cur_d, s, o;
    int e_val[NC], e_sop[NC], e_eop[NC], e_busy[NC], fi[NC], fq[NC], inc[NC];
    clear_stim();
    s_rst[0] = 1;
    for (int c = 2; c < n - 30; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        s_isop[c] = 1;
        s_ofs[c]  = int'($urandom_range(0, 6));
        s_len[c]  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
        if ($urandom_range(0, 1) == 0) begin
          s_pi[c] = int'($urandom_range(0, 4095)) - 2048;
          s_pq[c] = int'($urandom_range(0, 4095)) - 2048;
        end
      end
    end
    rcyc = int'($urandom_range(100, 250));
    s_rst[rcyc] = 1;
    run(n);
    busy_end = -1;
    for (int c = 0; c < n; c++) begin e_val[c] = 0; e_sop[c] = 0; e_eop[c] = 0; e_busy[c] = 0; fi[c] = 0; fq[c] = 0; inc[c] = 0; end
    for (int c = 0; c < n; c++) begin
      if (s_rst[c] != 0) begin
        for (int k = c + 1; k < n; k++) begin e_val[k] = 0; e_sop[k] = 0; e_eop[k] = 0; e_busy[k] = 0; end
        busy_end = c;
      end else if (s_isop[c] != 0) begin
        if (c <= busy_end) inc[c] = 1;
        else if (s_len[c] != 0) begin
          busy_end = c + s_ofs[c] + s_len[c];
          for (int k = c + 1; k <= busy_end && k < n; k++) e_busy[k] = 1;
          for (int j = 0; j < s_len[c]; j++) begin
            s = c + 1 + s_ofs[c] + j;
            o = s + 2;
            if (o < n) begin
              e_val[o] = 1; e_sop[o] = int'(j == 0); e_eop[o] = int'(j == s_len[c] - 1);
              fi[o] = sat_ref(longint'(s_di[s]) * s_pi[c] + longint'(s_dq[s]) * s_pq[c]);
              fq[o] = sat_ref(longint'(s_dq[s]) * s_pi[c] - longint'(s_di[s]) * s_pq[c]);
            end
          end
        end
      end
    end
    cur_i = 0; cur_q = 0; cur_d = 0;
    for (int c = 1; c < n; c++) begin
      if (s_rst[c-1] != 0) begin cur_i = 0; cur_q = 0; cur_d = 0; end
      else if (inc[c-1] != 0 && cur_d < 65535) cur_d++;
      if (e_val[c] != 0) begin cur_i = fi[c]; cur_q = fq[c]; end
      n_checks++;
      if (r_val[c] !== e_val[c] || r_sop[c] !== e_sop[c] || r_eop[c] !== e_eop[c]) begin
        n_fail++; $display("FAIL rand%0d_strobes cyc %0d: got val/sop/eop %0d%0d%0d expected %0d%0d%0d", iter, c, r_val[c], r_sop[c], r_eop[c], e_val[c], e_sop[c], e_eop[c]);
      end
      n_checks++;
      if (r_busy[c] !== e_busy[c]) begin n_fail++; $display("FAIL rand%0d_busy cyc %0d: got %0d expected %0d", iter, c, r_busy[c], e_busy[c]); end
      n_checks++;
      if (r_oi[c] !== cur_i || r_oq[c] !== cur_q) begin n_fail++; $display("FAIL rand%0d_data cyc %0d: got (%0d,%0d) expected (%0d,%0d)", iter, c, r_oi[c], r_oq[c], cur_i, cur_q); end
`ifdef SYNC_FRAME_EXTRACT_DROP_CNT_EN
      n_checks++;
      if (r_drop[c] !== cur_d) begin n_fail++; $display("FAIL rand%0d_drop cyc %0d: got %0d expected %0d", iter, c, r_drop[c], cur_d); end
`endif
    end
    $display("test_random %0d done (reset at cycle %0d)", iter, rcyc);
  endtask

  initial begin
    rst = 1'b1; isop = 1'b0; ipeak_i = '0; ipeak_q = '0;
    start_ofs = '0; frame_len = '0; idata_i = '0; idata_q = '0;
    test_reset();
    test_rotation("phase_rotation", 1024, 0, 100, -50);
    test_rotation("conjugate_rotation", 0, 1024, -50, -100);
    test_offset_timing();
    test_saturation();
    test_edge_lengths();
    test_overlap();
    test_back_to_back();
    test_reset_midframe();
    for (int i = 0; i < 3; i++) test_random(i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
